// File: rtl/fifo_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_reader
//  Description : Read-side burst controller for a synchronous FIFO. Tracks a
//                shadow occupancy count from the observed write strobe, pops
//                the requested number of words, and streams them through a
//                two-entry skid buffer on a valid/ready interface with a last
//                marker. Optional handshake statistics are enabled by defining
//                FIFO_READER_STATS_EN, which adds the word_cnt output.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_reader #(
    parameter int DW = 32,
    parameter int AW = 9,
    parameter int RS = 512,
    parameter int LW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fifo_push,
    output logic          fifo_pop,
    input  logic [DW-1:0] fifo_dout,
    input  logic          req_valid,
    input  logic [LW-1:0] req_len,
    output logic          req_ready,
    input  logic          abort,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          done,
    output logic          err_ovf
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [31:0]   word_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AW:0] c_lvl_max = (AW+1)'(RS);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW:0]   r_lvl;
    logic [LW-1:0] r_rem;
    logic [1:0]    r_buf_cnt;
    logic [DW-1:0] r_head_data;
    logic [DW-1:0] r_tail_data;
    logic          r_head_last;
    logic          r_tail_last;
    logic          r_err_ovf;

    logic          w_pop;
    logic          w_leave;
    logic          w_flush;
    logic          w_load;
    logic [1:0]    w_wr_pos;

    // A word leaves the head whenever the buffer is non-empty and accepted.
    assign w_leave  = (r_buf_cnt != 2'd0) && out_ready;
    // After an optional departure, the next free slot is where a popped word lands.
    assign w_wr_pos = r_buf_cnt - {1'b0, w_leave};

    assign fifo_pop  = w_pop;
    assign out_valid = (r_buf_cnt != 2'd0);
    assign out_data  = r_head_data;
    assign out_last  = r_head_last;
    assign err_ovf   = r_err_ovf;

    // Next-state and control decode; pop uses only registered terms plus abort.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_flush     = 1'b0;
        w_load      = 1'b0;
        req_ready   = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = (req_len == '0) ? S_DONE : S_BURST;
                end
            end
            S_BURST: begin
                if (abort) begin
                    w_flush     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_pop = (r_lvl != '0) && (r_rem != '0) && (r_buf_cnt != 2'd2);
                    if (w_pop && (r_rem == LW'(1))) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    w_flush     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if ((r_buf_cnt == 2'd0) || ((r_buf_cnt == 2'd1) && w_leave)) begin
                    // Enter DONE the cycle the buffer becomes empty.
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (rst) begin
            w_pop     = 1'b0;
            req_ready = 1'b0;
            done      = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Shadow FIFO occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lvl     <= '0;
            r_err_ovf <= 1'b0;
        end else begin
            case ({fifo_push, w_pop})
                2'b10: begin
                    if (r_lvl == c_lvl_max) r_err_ovf <= 1'b1;
                    else                    r_lvl     <= r_lvl + 1'b1;
                end
                2'b01:   r_lvl <= r_lvl - 1'b1;
                default: r_lvl <= r_lvl;
            endcase
        end
    end

    // Remaining words to pop in the current burst.
    always_ff @(posedge clk) begin
        if (rst || w_flush) r_rem <= '0;
        else if (w_load)    r_rem <= req_len;
        else if (w_pop)     r_rem <= r_rem - 1'b1;
    end

    // Two-entry skid buffer: shift on departure, capture popped word at the tail.
    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_buf_cnt   <= 2'd0;
            r_head_data <= '0;
            r_tail_data <= '0;
            r_head_last <= 1'b0;
            r_tail_last <= 1'b0;
        end else begin
            if (w_leave) begin
                r_head_data <= r_tail_data;
                r_head_last <= r_tail_last;
            end
            if (w_pop) begin
                if (w_wr_pos == 2'd0) begin
                    r_head_data <= fifo_dout;
                    r_head_last <= (r_rem == LW'(1));
                end else begin
                    r_tail_data <= fifo_dout;
                    r_tail_last <= (r_rem == LW'(1));
                end
            end
            r_buf_cnt <= r_buf_cnt + {1'b0, w_pop} - {1'b0, w_leave};
        end
    end

`ifdef FIFO_READER_STATS_EN
    logic [31:0] r_word_cnt;
    assign word_cnt = r_word_cnt;

    // Saturating count of completed output handshakes; survives abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_cnt <= '0;
        end else if (out_valid && out_ready && (r_word_cnt != 32'hFFFF_FFFF)) begin
            r_word_cnt <= r_word_cnt + 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_reader
//  Description : Directed plus randomized bench for fifo_reader with a FIFO
//                model and an in-order word reference list.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_reader;

    localparam int RS = 512;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_push = 1'b0;
    logic        fifo_pop;
    logic [31:0] fifo_dout = '0;
    logic        req_valid = 1'b0;
    logic [15:0] req_len = '0;
    logic        req_ready;
    logic        abort = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic        done;
    logic        err_ovf;
`ifdef FIFO_READER_STATS_EN
    logic [31:0] word_cnt;
`endif

    fifo_reader dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_push (fifo_push),
        .fifo_pop  (fifo_pop),
        .fifo_dout (fifo_dout),
        .req_valid (req_valid),
        .req_len   (req_len),
        .req_ready (req_ready),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done),
        .err_ovf   (err_ovf)
`ifdef FIFO_READER_STATS_EN
        ,
        .word_cnt  (word_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: every word ever accepted into the FIFO, in order; rd_idx is
    // the index of the next word a burst must deliver.
    logic [31:0] pushed[$];
    int          rd_idx = 0;

    // FIFO model: sample strobes mid-cycle, apply them just after the edge.
    logic [31:0] fq[$];
    logic [31:0] wdata = '0;
    logic        s_push, s_pop, s_rst;
    logic [31:0] s_d;
    always @(negedge clk) begin
        s_push = fifo_push;
        s_pop  = fifo_pop;
        s_rst  = rst;
        s_d    = wdata;
        @(posedge clk);
        #1;
        if (s_rst) begin
            fq.delete();
        end else begin
            if (s_pop && fq.size() > 0) void'(fq.pop_front());
            if (s_push && fq.size() < RS) fq.push_back(s_d);
        end
        fifo_dout = (fq.size() > 0) ? fq[0] : '0;
    end

    // Monitor: record handshakes, pops, done pulses and valid cycles.
    int          cyc = 0, n_pop = 0, n_done = 0, n_ov = 0, acc_cyc = 0, done_cyc = 0;
    logic [31:0] got_d[$];
    logic        got_l[$];
    int          hs_cyc[$];
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_l.push_back(out_last);
                hs_cyc.push_back(cyc);
            end
            if (fifo_pop) n_pop++;
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (out_valid) n_ov++;
            if (req_valid && req_ready) acc_cyc = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        got_d.delete();
        got_l.delete();
        hs_cyc.delete();
        n_pop  = 0;
        n_done = 0;
        n_ov   = 0;
    endtask

    task automatic push_word(input logic [31:0] d);
        fifo_push = 1'b1;
        wdata     = d;
        pushed.push_back(d);
        step();
        fifo_push = 1'b0;
    endtask

    task automatic request(input int len);
        req_valid = 1'b1;
        req_len   = len[15:0];
        chk("req_ready_at_request", req_ready, 1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d0 = n_done;
        int k  = 0;
        while (n_done == d0 && k < budget) begin
            step();
            k++;
        end
        chk(tag, (n_done != d0), 1);
    endtask

    task automatic check_burst(input int len, input string tag);
        chk({tag, "_count"}, got_d.size(), len);
        for (int i = 0; i < len && i < got_d.size(); i++) begin
            chk({tag, "_data"}, got_d[i], pushed[rd_idx+i]);
            chk({tag, "_last"}, got_l[i], (i == len-1));
        end
        rd_idx += len;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        pushed.delete();
        rd_idx = 0;
        step();
    endtask

    initial begin
        int k;
        int ov0;
        int len;
        int d0;

        // Reset values
        rst = 1'b1;
        repeat (2) step();
        chk("rst_fifo_pop",  fifo_pop,  0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data,  0);
        chk("rst_out_last",  out_last,  0);
        chk("rst_done",      done,      0);
        chk("rst_err_ovf",   err_ovf,   0);
`ifdef FIFO_READER_STATS_EN
        chk("rst_word_cnt",  word_cnt,  0);
`endif
        rst = 1'b0;
        step();
        chk("idle_req_ready", req_ready, 1);

        // Test 1: 8 words 0x10..0x17 streamed back-to-back
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push_word(32'h10 + i);
        clr();
        request(8);
        wait_done(40, "t1_done_seen");
        if (hs_cyc.size() == 8) begin
            chk("t1_first_latency", hs_cyc[0], acc_cyc + 2);
            for (int i = 1; i < 8; i++) chk("t1_consecutive", hs_cyc[i] - hs_cyc[i-1], 1);
            chk("t1_done_timing", done_cyc, hs_cyc[7] + 1);
        end
        check_burst(8, "t1");
`ifdef FIFO_READER_STATS_EN
        chk("t1_word_cnt", word_cnt, 8);
`endif

        // Test 2: empty FIFO, one push every 3 cycles
        clr();
        request(4);
        repeat (5) step();
        chk("t2_no_pop_while_empty", n_pop, 0);
        for (int i = 0; i < 4; i++) begin
            push_word($urandom);
            step();
            step();
            chk("t2_pop_after_push", n_pop, i + 1);
            if (i < 3) begin
                chk("t2_still_busy", req_ready, 0);
                chk("t2_no_done_yet", n_done, 0);
            end
        end
        wait_done(20, "t2_done_seen");
        check_burst(4, "t2");

        // Test 3: consumer stalls, buffer fills to 2, data holds steady
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_word($urandom);
        clr();
        request(6);
        repeat (3) step();
        for (int i = 0; i < 8; i++) begin
            chk("t3_stall_valid", out_valid, 1);
            chk("t3_stall_data",  out_data,  pushed[rd_idx]);
            step();
        end
        chk("t3_two_pops", n_pop, 2);
        out_ready = 1'b1;
        wait_done(30, "t3_done_seen");
        check_burst(6, "t3");

        // Test 4: zero-length request
        clr();
        request(0);
        chk("t4_busy",      req_ready, 0);
        chk("t4_done",      done,      1);
        step();
        chk("t4_ready_back", req_ready, 1);
        chk("t4_done_once",  done,      0);
        chk("t4_no_pop",     n_pop,     0);
        chk("t4_no_valid",   n_ov,      0);

        // Test 5: abort during the 5th handshake
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) push_word($urandom);
        clr();
        request(20);
        k = 0;
        while (!(got_d.size() == 4 && out_valid) && k < 50) begin
            step();
            k++;
        end
        chk("t5_reached_5th", (k < 50), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        ov0 = n_ov;
        repeat (10) step();
        chk("t5_no_more_valid", n_ov,         ov0);
        chk("t5_no_done",       n_done,       0);
        chk("t5_pops_issued",   n_pop,        5);
        chk("t5_hs_count",      got_d.size(), 5);
        chk("t5_idle",          req_ready,    1);
        for (int i = 0; i < 5 && i < got_d.size(); i++) chk("t5_data", got_d[i], pushed[rd_idx+i]);
        rd_idx += 5;
        clr();
        request(3);
        wait_done(30, "t5_next_done_seen");
        check_burst(3, "t5_next");

        // Test 6: overflow detection and stickiness
        do_reset();
        for (int i = 0; i < RS; i++) push_word($urandom);
        chk("t6_full_no_ovf", err_ovf, 0);
        fifo_push = 1'b1;
        wdata     = $urandom;
        step();
        fifo_push = 1'b0;
        chk("t6_ovf_set", err_ovf, 1);
        repeat (5) step();
        chk("t6_ovf_sticky", err_ovf, 1);
        clr();
        request(3);
        wait_done(30, "t6_read_done_seen");
        check_burst(3, "t6_read");
        chk("t6_ovf_still", err_ovf, 1);
        do_reset();
        chk("t6_ovf_cleared", err_ovf, 0);

        // Randomized bursts with random pushes and back-pressure
        for (int b = 0; b < 6; b++) begin
            len = $urandom_range(1, 12);
            clr();
            out_ready = 1'b1;
            request(len);
            d0 = n_done;
            k  = 0;
            while (n_done == d0 && k < 300) begin
                if ($urandom_range(0, 1) == 1 && (pushed.size() - rd_idx) < 400) begin
                    fifo_push = 1'b1;
                    wdata     = $urandom;
                    pushed.push_back(wdata);
                end else begin
                    fifo_push = 1'b0;
                end
                out_ready = ($urandom_range(0, 3) != 0);
                step();
                k++;
            end
            fifo_push = 1'b0;
            out_ready = 1'b1;
            chk("rnd_done_seen", (n_done != d0), 1);
            check_burst(len, "rnd");
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
